mips_alu_pc_unit: RTL and testbench
===================================

Name: mips_alu_pc_unit

Overview:
Execute-stage core of the single-cycle MIPS Harvard CPU. It merges three functions:
- Program-counter register.
- PC+4 and branch-target adders.
- Main ALU, which decodes opcode/funct directly and produces the ALU result, the branch-taken flag and the next HI/LO values.

The top level routes alu_result to the data address and to the writeback mux. HI/LO storage registers live outside this block.

Parameters:
RESET_VECTOR, 32'hBFC00000, value loaded into the PC on reset.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
clk_enable  input  1  PC update enable.
pc_in  input  32  next PC, selected externally (branch/jump/JR mux).
pc_out  output  32  current PC; drives instr_address.
pc_plus4  output  32  pc_out + 4.
branch_target  output  32  pc_plus4 + (sign_extend(immediate) << 2).
opcode  input  6  instr[31:26].
functcode  input  6  instr[5:0].
shamt  input  5  instr[10:6].
rt_sel  input  5  instr[20:16]; selects the REGIMM sub-op.
immediate  input  16  instr[15:0].
rs_content  input  32  register rs value.
rt_content  input  32  register rt value.
hi_reg  input  32  current HI register; used by MFHI.
lo_reg  input  32  current LO register; used by MFLO.
alu_result  output  32  ALU result / memory address.
sig_branch  output  1  conditional branch taken.
hi  output  32  next HI value.
lo  output  32  next LO value.

Behaviour:
- PC register:
  - reset=1 asynchronously forces pc_out=RESET_VECTOR.
  - On a rising clk with clk_enable=1: pc_out<=pc_in. With clk_enable=0 it holds.
  - No other state in the block.
- Adders: pc_plus4 and branch_target are combinational, modulo 2^32 (wrap, no flag).
- ALU: fully combinational, zero latency. Default for every output: alu_result=0, sig_branch=0, hi=0, lo=0. Unrecognised opcode/funct leaves all defaults.
- R-type (opcode 00), by funct:
  - Shifts: 00 SLL, 02 SRL, 03 SRA use rt by shamt. 04 SLLV, 06 SRLV, 07 SRAV use rt by rs[4:0].
  - Arithmetic/logic: 21 ADDU rs+rt; 23 SUBU rs-rt; 24 AND; 25 OR; 26 XOR; 27 NOR.
  - Compares: 2A SLT (signed), 2B SLTU (unsigned); result 1 or 0.
  - Jumps: 08 JR and 09 JALR give alu_result=0 (PC select is external).
  - HI/LO moves: 10 MFHI -> hi_reg; 12 MFLO -> lo_reg; 11 MTHI hi=rs; 13 MTLO lo=rs.
  - Multiply/divide: 18 MULT, 19 MULTU, 1A DIV, 1B DIVU (see Optional Feature).
- I-type, by opcode:
  - 09 ADDIU rs+sext(imm).
  - 0A SLTI signed compare; 0B SLTIU compares unsigned against sext(imm).
  - 0C ANDI, 0D ORI, 0E XORI use zero-extended imm.
  - 0F LUI: imm<<16.
- Loads/stores, opcodes 20–26, 28, 29, 2B: alu_result=rs+sext(imm). No alignment check.
- Branches (alu_result=0):
  - 04 BEQ rs==rt; 05 BNE rs!=rt; 06 BLEZ rs<=0 signed; 07 BGTZ rs>0 signed.
  - 01 REGIMM: rt_sel 00 BLTZ, 10 BLTZAL take if rs<0. rt_sel 01 BGEZ, 11 BGEZAL take if rs>=0.
  - sig_branch=1 when the condition holds.
- J/JAL (02/03): all outputs at defaults.
- Reset mid-operation: the PC goes to RESET_VECTOR immediately. ALU outputs follow their inputs regardless of reset.

Optional Feature:
Macro ALU_MULDIV_EN.
- Defined:
  - MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product of rs and rt.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divisor 0: hi=0, lo=0.
- Undefined: the four ops leave hi=lo=0 and alu_result=0. MTHI/MTLO are unaffected.

Test Plan:
1. Assert reset mid-cycle with pc_in=0x100 -> pc_out=0xBFC00000 immediately. Release reset, clk_enable=1, pc_in=0x100 -> pc_out=0x100 at the next edge. clk_enable=0 -> pc_out holds.
2. pc_out=0xBFC00000, immediate=0xFFFF -> pc_plus4=0xBFC00004, branch_target=0xBFC00000. pc_out=0xFFFFFFFC -> pc_plus4=0.
3. ADDU 0x7FFFFFFF+1 -> 0x80000000. SLT rs=-1 rt=1 -> 1; SLTU -> 0. SRA rt=0x80000000 shamt=4 -> 0xF8000000. LUI imm=0x1234 -> 0x12340000.
4. ORI rs=0xFFFF0000 imm=0x8001 -> 0xFFFF8001. LW rs=0x1000 imm=0xFFFC -> alu_result=0x0FFC.
5. BEQ with equal operands -> sig_branch=1. BGTZ rs=0 -> 0. REGIMM rt_sel=01, rs=0 -> 1. BLTZ rs=0x80000000 -> 1.
6. With ALU_MULDIV_EN: MULT rs=-2 rt=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; DIV rs=-7 rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU by 0 -> hi=lo=0. MTHI rs=5 -> hi=5.

Source files
------------

// File: rtl/mips_alu_pc_unit.sv
// mips_alu_pc_unit
// Execute-stage core of a single-cycle MIPS Harvard CPU. The block has three parts:
//   - the program-counter register (the only state in the block)
//   - the PC+4 and branch-target adders (combinational, wrap modulo 2^32)
//   - the main ALU, which decodes opcode/funct directly and produces the ALU
//     result, the branch-taken flag and the next HI/LO values
//     (combinational, zero latency)
// The HI/LO storage registers live outside this block.
//
// Optional feature: define ALU_MULDIV_EN to enable MULT/MULTU/DIV/DIVU.
// Without it, those four ops leave hi = lo = 0 and alu_result = 0.
//
// Ports:
//   clk            in   1   system clock, rising edge
//   reset          in   1   asynchronous, active-high; forces pc_out to RESET_VECTOR
//   clk_enable     in   1   PC update enable
//   pc_in          in  32   next PC (selected outside this block)
//   pc_out         out 32   current PC
//   pc_plus4       out 32   pc_out + 4
//   branch_target  out 32   pc_plus4 + (sign_extend(immediate) << 2)
//   opcode         in   6   instr[31:26]
//   functcode      in   6   instr[5:0]
//   shamt          in   5   instr[10:6]
//   rt_sel         in   5   instr[20:16], selects the REGIMM sub-op
//   immediate      in  16   instr[15:0]
//   rs_content     in  32   register rs value
//   rt_content     in  32   register rt value
//   hi_reg         in  32   current HI value (read by MFHI)
//   lo_reg         in  32   current LO value (read by MFLO)
//   alu_result     out 32   ALU result / memory address
//   sig_branch     out  1   conditional branch taken
//   hi             out 32   next HI value
//   lo             out 32   next LO value
module mips_alu_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target,
  input  logic [5:0]  opcode,
  input  logic [5:0]  functcode,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rt_sel,
  input  logic [15:0] immediate,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  input  logic [31:0] hi_reg,
  input  logic [31:0] lo_reg,
  output logic [31:0] alu_result,
  output logic        sig_branch,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LWL    = 6'h22;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_LWR    = 6'h26;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // REGIMM sub-ops (rt field)
  localparam logic [4:0] RI_BLTZ   = 5'h00;
  localparam logic [4:0] RI_BGEZ   = 5'h01;
  localparam logic [4:0] RI_BLTZAL = 5'h10;
  localparam logic [4:0] RI_BGEZAL = 5'h11;

  // Operand views
  logic        [31:0] imm_sext;
  logic        [31:0] imm_zext;
  logic signed [31:0] rs_s;
  logic signed [31:0] rt_s;
  logic signed [31:0] imm_s;

  assign imm_sext = {{16{immediate[15]}}, immediate};
  assign imm_zext = {16'h0000, immediate};
  assign rs_s     = rs_content;
  assign rt_s     = rt_content;
  assign imm_s    = imm_sext;

  // PC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out <= RESET_VECTOR;
    end else if (clk_enable) begin
      pc_out <= pc_in;
    end
  end

  // Address adders
  assign pc_plus4      = pc_out + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};

  // Sign-preserving right shift by a 5-bit amount.
  function automatic logic [31:0] shift_ra(input logic [31:0] val, input logic [4:0] amt);
    logic signed [31:0] v;
    v = val;
    return v >>> amt;
  endfunction

`ifdef ALU_MULDIV_EN
  // Signed division on magnitudes so -2^31 / -1 wraps instead of trapping.
  // The quotient truncates toward zero and the remainder takes the sign of
  // the dividend. A zero divisor yields zero for both.
  // Returns {remainder, quotient}.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q;
    logic [31:0] r;
    a_mag = a[31] ? (32'd0 - a) : a;
    b_mag = b[31] ? (32'd0 - b) : b;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (b != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    q = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
    r = a[31] ? (32'd0 - r_mag) : r_mag;
    return {r, q};
  endfunction

  // Unsigned division; a zero divisor yields zero for both halves.
  // Returns {remainder, quotient}.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] res;
    res = 64'd0;
    if (b != 32'd0) begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] div_s;
  logic        [63:0] div_u;

  assign prod_s = rs_s * rt_s;
  assign prod_u = {32'd0, rs_content} * {32'd0, rt_content};
  assign div_s  = div_signed(rs_content, rt_content);
  assign div_u  = div_unsigned(rs_content, rt_content);
`endif

  // Main ALU: every output starts at zero; unrecognised encodings keep it.
  always_comb begin
    alu_result = 32'd0;
    sig_branch = 1'b0;
    hi         = 32'd0;
    lo         = 32'd0;

    case (opcode)
      OP_RTYPE: begin
        case (functcode)
          FN_SLL:  alu_result = rt_content << shamt;
          FN_SRL:  alu_result = rt_content >> shamt;
          FN_SRA:  alu_result = shift_ra(rt_content, shamt);
          FN_SLLV: alu_result = rt_content << rs_content[4:0];
          FN_SRLV: alu_result = rt_content >> rs_content[4:0];
          FN_SRAV: alu_result = shift_ra(rt_content, rs_content[4:0]);
          FN_ADDU: alu_result = rs_content + rt_content;
          FN_SUBU: alu_result = rs_content - rt_content;
          FN_AND:  alu_result = rs_content & rt_content;
          FN_OR:   alu_result = rs_content | rt_content;
          FN_XOR:  alu_result = rs_content ^ rt_content;
          FN_NOR:  alu_result = ~(rs_content | rt_content);
          FN_SLT:  alu_result = {31'd0, rs_s < rt_s};
          FN_SLTU: alu_result = {31'd0, rs_content < rt_content};
          // The jump target is selected outside this block.
          FN_JR, FN_JALR: alu_result = 32'd0;
          FN_MFHI: alu_result = hi_reg;
          FN_MFLO: alu_result = lo_reg;
          FN_MTHI: hi = rs_content;
          FN_MTLO: lo = rs_content;
`ifdef ALU_MULDIV_EN
          FN_MULT:  {hi, lo} = prod_s;
          FN_MULTU: {hi, lo} = prod_u;
          FN_DIV:   {hi, lo} = div_s;
          FN_DIVU:  {hi, lo} = div_u;
`else
          // Multiply/divide not built: the outputs keep their zero defaults.
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            hi = 32'd0;
            lo = 32'd0;
          end
`endif
          default: alu_result = 32'd0;
        endcase
      end

      OP_ADDIU: alu_result = rs_content + imm_sext;
      OP_SLTI:  alu_result = {31'd0, rs_s < imm_s};
      OP_SLTIU: alu_result = {31'd0, rs_content < imm_sext};
      OP_ANDI:  alu_result = rs_content & imm_zext;
      OP_ORI:   alu_result = rs_content | imm_zext;
      OP_XORI:  alu_result = rs_content ^ imm_zext;
      OP_LUI:   alu_result = {immediate, 16'h0000};

      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
      OP_SB, OP_SH, OP_SW:
        alu_result = rs_content + imm_sext;

      OP_BEQ:  sig_branch = (rs_content == rt_content);
      OP_BNE:  sig_branch = (rs_content != rt_content);
      OP_BLEZ: sig_branch = (rs_s <= 32'sd0);
      OP_BGTZ: sig_branch = (rs_s > 32'sd0);

      OP_REGIMM: begin
        case (rt_sel)
          RI_BLTZ, RI_BLTZAL: sig_branch = (rs_s < 32'sd0);
          RI_BGEZ, RI_BGEZAL: sig_branch = (rs_s >= 32'sd0);
          default:            sig_branch = 1'b0;
        endcase
      end

      // The jump target is formed outside this block.
      OP_J, OP_JAL: alu_result = 32'd0;

      default: alu_result = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mips_alu_pc_unit.sv
// tb_mips_alu_pc_unit
// Directed vectors for mips_alu_pc_unit. The stimulus process drives each
// vector just after a rising edge, pushes the hand-computed response into a
// scoreboard queue and raises out_vld. The monitor compares on the falling
// edge while out_vld is high.
module tb_mips_alu_pc_unit;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [5:0]  opcode;
  logic [5:0]  functcode;
  logic [4:0]  shamt;
  logic [4:0]  rt_sel;
  logic [15:0] immediate;
  logic [31:0] rs_content;
  logic [31:0] rt_content;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [31:0] alu_result;
  logic        sig_branch;
  logic [31:0] hi;
  logic [31:0] lo;

  mips_alu_pc_unit #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .pc_in         (pc_in),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .opcode        (opcode),
    .functcode     (functcode),
    .shamt         (shamt),
    .rt_sel        (rt_sel),
    .immediate     (immediate),
    .rs_content    (rs_content),
    .rt_content    (rt_content),
    .hi_reg        (hi_reg),
    .lo_reg        (lo_reg),
    .alu_result    (alu_result),
    .sig_branch    (sig_branch),
    .hi            (hi),
    .lo            (lo)
  );

  typedef struct {
    string       name;
    bit          chk_pc;
    logic [31:0] res;
    logic        br;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] bt;
  } exp_t;

  exp_t sb[$];
  logic out_vld;
  int   n_tests;
  int   n_fail;
  bit   done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    if (out_vld) begin
      exp_t e;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: output presented with no expected entry");
      end else begin
        e = sb.pop_front();
        if (e.chk_pc) begin
          if (pc_out !== e.pc || pc_plus4 !== e.p4 || branch_target !== e.bt) begin
            n_fail++;
            $display("FAIL %s: pc=%h p4=%h bt=%h, expected pc=%h p4=%h bt=%h",
                     e.name, pc_out, pc_plus4, branch_target, e.pc, e.p4, e.bt);
          end
        end else begin
          if (alu_result !== e.res || sig_branch !== e.br || hi !== e.hi || lo !== e.lo) begin
            n_fail++;
            $display("FAIL %s: res=%h br=%b hi=%h lo=%h, expected res=%h br=%b hi=%h lo=%h",
                     e.name, alu_result, sig_branch, hi, lo, e.res, e.br, e.hi, e.lo);
          end
        end
      end
    end
  end

  task automatic pc_vec(input string name, input logic rst_v, input logic ce,
                        input logic [31:0] pin, input logic [15:0] imm,
                        input logic [31:0] e_pc, input logic [31:0] e_p4,
                        input logic [31:0] e_bt);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst_v;
    clk_enable = ce;
    pc_in      = pin;
    immediate  = imm;
    opcode     = 6'h02;
    e.name = name; e.chk_pc = 1'b1;
    e.res = '0; e.br = 1'b0; e.hi = '0; e.lo = '0;
    e.pc = e_pc; e.p4 = e_p4; e.bt = e_bt;
    sb.push_back(e);
    out_vld = 1'b1;
  endtask

  task automatic alu_vec(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [4:0] rsel, input logic [15:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] e_res, input logic e_br,
                         input logic [31:0] e_hi, input logic [31:0] e_lo);
    exp_t e;
    @(posedge clk);
    #1;
    opcode     = op;
    functcode  = fn;
    shamt      = sh;
    rt_sel     = rsel;
    immediate  = imm;
    rs_content = rs;
    rt_content = rt;
    e.name = name; e.chk_pc = 1'b0;
    e.res = e_res; e.br = e_br; e.hi = e_hi; e.lo = e_lo;
    e.pc = '0; e.p4 = '0; e.bt = '0;
    sb.push_back(e);
    out_vld = 1'b1;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0; n_fail = 0; out_vld = 1'b0; done = 1'b0;
    reset = 1'b0; clk_enable = 1'b0; pc_in = '0;
    opcode = '0; functcode = '0; shamt = '0; rt_sel = '0; immediate = '0;
    rs_content = '0; rt_content = '0;
    hi_reg = 32'hAAAA5555; lo_reg = 32'h1234ABCD;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // PC register and adders
    pc_vec("reset_state",   1'b1, 1'b1, 32'h100, 16'h0000, 32'hBFC00000, 32'hBFC00004, 32'hBFC00004);
    pc_vec("adders_neg_imm",1'b0, 1'b1, 32'h100, 16'hFFFF, 32'hBFC00000, 32'hBFC00004, 32'hBFC00000);
    pc_vec("pc_load",       1'b0, 1'b0, 32'h200, 16'h0004, 32'h00000100, 32'h00000104, 32'h00000114);
    pc_vec("pc_hold",       1'b0, 1'b0, 32'h200, 16'h0004, 32'h00000100, 32'h00000104, 32'h00000114);
    pc_vec("async_reset",   1'b1, 1'b0, 32'h100, 16'h0000, 32'hBFC00000, 32'hBFC00004, 32'hBFC00004);
    pc_vec("reset_release", 1'b0, 1'b1, 32'hFFFFFFFC, 16'h0000, 32'hBFC00000, 32'hBFC00004, 32'hBFC00004);
    pc_vec("pc_plus4_wrap", 1'b0, 1'b0, 32'h0, 16'h0001, 32'hFFFFFFFC, 32'h00000000, 32'h00000004);

    // R-type arithmetic, logic and shifts
    alu_vec("addu_ovf", 6'h00, 6'h21, 5'd0, 5'd0, 16'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, '0, '0);
    alu_vec("subu",     6'h00, 6'h23, 5'd0, 5'd0, 16'h0, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, '0, '0);
    alu_vec("slt",      6'h00, 6'h2A, 5'd0, 5'd0, 16'h0, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, '0, '0);
    alu_vec("sltu",     6'h00, 6'h2B, 5'd0, 5'd0, 16'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, '0, '0);
    alu_vec("sra",      6'h00, 6'h03, 5'd4, 5'd0, 16'h0, 32'h0, 32'h80000000, 32'hF8000000, 1'b0, '0, '0);
    alu_vec("srl",      6'h00, 6'h02, 5'd4, 5'd0, 16'h0, 32'h0, 32'h80000000, 32'h08000000, 1'b0, '0, '0);
    alu_vec("sll",      6'h00, 6'h00, 5'd8, 5'd0, 16'h0, 32'h0, 32'h12345678, 32'h34567800, 1'b0, '0, '0);
    alu_vec("sllv",     6'h00, 6'h04, 5'd0, 5'd0, 16'h0, 32'h23, 32'h1, 32'h8, 1'b0, '0, '0);
    alu_vec("srav",     6'h00, 6'h07, 5'd0, 5'd0, 16'h0, 32'd31, 32'h80000000, 32'hFFFFFFFF, 1'b0, '0, '0);
    alu_vec("nor",      6'h00, 6'h27, 5'd0, 5'd0, 16'h0, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0, '0, '0);
    alu_vec("xor",      6'h00, 6'h26, 5'd0, 5'd0, 16'h0, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, '0, '0);
    alu_vec("and",      6'h00, 6'h24, 5'd0, 5'd0, 16'h0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, '0, '0);

    // I-type
    alu_vec("lui",      6'h0F, 6'h00, 5'd0, 5'd0, 16'h1234, 32'hFFFFFFFF, 32'h0, 32'h12340000, 1'b0, '0, '0);
    alu_vec("ori",      6'h0D, 6'h00, 5'd0, 5'd0, 16'h8001, 32'hFFFF0000, 32'h0, 32'hFFFF8001, 1'b0, '0, '0);
    alu_vec("andi_zext",6'h0C, 6'h00, 5'd0, 5'd0, 16'h8001, 32'hFFFFFFFF, 32'h0, 32'h00008001, 1'b0, '0, '0);
    alu_vec("addiu",    6'h09, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'h10, 32'h0, 32'h0000000F, 1'b0, '0, '0);
    alu_vec("sltiu",    6'h0B, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'd5, 32'h0, 32'h1, 1'b0, '0, '0);
    alu_vec("slti",     6'h0A, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'd5, 32'h0, 32'h0, 1'b0, '0, '0);
    alu_vec("lw_addr",  6'h23, 6'h00, 5'd0, 5'd0, 16'hFFFC, 32'h1000, 32'h0, 32'h00000FFC, 1'b0, '0, '0);
    alu_vec("sb_addr",  6'h28, 6'h00, 5'd0, 5'd0, 16'h7FFF, 32'h0, 32'h0, 32'h00007FFF, 1'b0, '0, '0);

    // Branches
    alu_vec("beq_eq",   6'h04, 6'h00, 5'd0, 5'd0, 16'h0010, 32'h55, 32'h55, 32'h0, 1'b1, '0, '0);
    alu_vec("bne_eq",   6'h05, 6'h00, 5'd0, 5'd0, 16'h0010, 32'h55, 32'h55, 32'h0, 1'b0, '0, '0);
    alu_vec("bgtz_0",   6'h07, 6'h00, 5'd0, 5'd0, 16'h0010, 32'h0, 32'h0, 32'h0, 1'b0, '0, '0);
    alu_vec("blez_0",   6'h06, 6'h00, 5'd0, 5'd0, 16'h0010, 32'h0, 32'h0, 32'h0, 1'b1, '0, '0);
    alu_vec("bgez_0",   6'h01, 6'h00, 5'd0, 5'h01, 16'h0010, 32'h0, 32'h0, 32'h0, 1'b1, '0, '0);
    alu_vec("bltz_min", 6'h01, 6'h00, 5'd0, 5'h00, 16'h0010, 32'h80000000, 32'h0, 32'h0, 1'b1, '0, '0);
    alu_vec("bltzal_1", 6'h01, 6'h00, 5'd0, 5'h10, 16'h0010, 32'h1, 32'h0, 32'h0, 1'b0, '0, '0);

    // HI/LO moves, jumps, unrecognised encodings
    alu_vec("mfhi",     6'h00, 6'h10, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'hAAAA5555, 1'b0, '0, '0);
    alu_vec("mflo",     6'h00, 6'h12, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h1234ABCD, 1'b0, '0, '0);
    alu_vec("mthi",     6'h00, 6'h11, 5'd0, 5'd0, 16'h0, 32'd5, 32'h0, 32'h0, 1'b0, 32'd5, '0);
    alu_vec("mtlo",     6'h00, 6'h13, 5'd0, 5'd0, 16'h0, 32'd9, 32'h0, 32'h0, 1'b0, '0, 32'd9);
    alu_vec("jr",       6'h00, 6'h08, 5'd0, 5'd0, 16'h0, 32'h1234, 32'h5678, 32'h0, 1'b0, '0, '0);
    alu_vec("j",        6'h02, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'h1234, 32'h1234, 32'h0, 1'b0, '0, '0);
    alu_vec("bad_funct",6'h00, 6'h3F, 5'd0, 5'd0, 16'h0, 32'h1234, 32'h5678, 32'h0, 1'b0, '0, '0);
    alu_vec("bad_op",   6'h3E, 6'h21, 5'd0, 5'd0, 16'h0, 32'h1234, 32'h5678, 32'h0, 1'b0, '0, '0);

    // Multiply / divide
`ifdef ALU_MULDIV_EN
    alu_vec("mult",     6'h00, 6'h18, 5'd0, 5'd0, 16'h0, 32'hFFFFFFFE, 32'd3, 32'h0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    alu_vec("multu",    6'h00, 6'h19, 5'd0, 5'd0, 16'h0, 32'hFFFFFFFF, 32'd2, 32'h0, 1'b0, 32'h00000001, 32'hFFFFFFFE);
    alu_vec("div",      6'h00, 6'h1A, 5'd0, 5'd0, 16'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    alu_vec("divu_0",   6'h00, 6'h1B, 5'd0, 5'd0, 16'h0, 32'd17, 32'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    alu_vec("divu",     6'h00, 6'h1B, 5'd0, 5'd0, 16'h0, 32'd17, 32'd5, 32'h0, 1'b0, 32'd2, 32'd3);
`else
    alu_vec("mult_off", 6'h00, 6'h18, 5'd0, 5'd0, 16'h0, 32'hFFFFFFFE, 32'd3, 32'h0, 1'b0, 32'h0, 32'h0);
    alu_vec("div_off",  6'h00, 6'h1A, 5'd0, 5'd0, 16'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 32'h0, 32'h0);
    alu_vec("divu_0",   6'h00, 6'h1B, 5'd0, 5'd0, 16'h0, 32'd17, 32'd0, 32'h0, 1'b0, 32'h0, 32'h0);
`endif

    @(posedge clk);
    #1 out_vld = 1'b0;
    @(posedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    done = 1'b1;
    $finish;
  end

endmodule
